mem_arbiter: RTL and testbench

Two-port burst arbiter that shares the single external memory controller port between the program-space cache (port 1, read-only) and the data-space cache (port 2, read/write). It sits between the two cache controllers and the SDRAM controller command/data interface. It grants one whole burst at a time with round-robin fairness and returns a one-cycle completion pulse per transaction.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_arb2.sv | 41 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory burst arbiter.
package mem_arb_pkg;

    // Default number of beats per burst (power of two, >= 2).
    localparam int BURST_LEN_DEF = 4;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_e;

    // Which cache port owns the memory controller.
    typedef enum logic {
        GNT_P1,
        GNT_P2
    } grant_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The grant is a pure function of the
// requests and of the last port served; last_grant only moves when a
// transaction completes, so a tie always goes to the port that waited.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_p1,
    input  logic req_p2,
    input  logic done,
    input  logic done_p2,
    output logic any_req,
    output logic gnt_p2
);

    grant_e last_grant;

    // Choose the port to grant; a tie goes to the port not served last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        any_req = req_p1 | req_p2;
        gnt_p2  = 1'b0;
        if (req_p1 && req_p2) begin
            gnt_p2 = (last_grant == GNT_P1);
        end else begin
            gnt_p2 = req_p2;
        end
    end

    // Remember which port finished last; reset favours p2 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_P1;
        end else if (done) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            last_grant <= done_p2 ? GNT_P2 : GNT_P1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter sharing one SDRAM controller port between the program
// cache (p1, read-only) and the data cache (p2, read/write). One whole
// burst is granted at a time and each transaction ends with a done pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              p1_done,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    output logic              p2_wnext,
    output logic [DATA_W-1:0] p2_rdata,
    output logic              p2_rvalid,
    output logic              p2_done,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wready,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int              CNT_W     = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  cnt;
    grant_e            gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              arb_any;
    logic              arb_p2;
    logic              beat;
    logic              rd_beat;
    logic              start;
    logic [ADDR_W-1:0] req_addr;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_p1  (p1_req),
        .req_p2  (p2_req),
        .done    (state == DONE),
        .done_p2 (gnt_q == GNT_P2),
        .any_req (arb_any),
        .gnt_p2  (arb_p2)
    );

    // Beat qualification: memory handshakes only count while in DATA.
    always_comb begin
        start    = (state == IDLE) && arb_any;
        beat     = (state == DATA) && (we_q ? mem_wready : mem_rvalid);
        rd_beat  = beat && !we_q;
        req_addr = arb_p2 ? p2_addr : p1_addr;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and decoded handshake outputs.
    always_comb begin
        state_nxt     = state;
        mem_cmd_valid = 1'b0;
        p1_done       = 1'b0;
        p2_done       = 1'b0;
        p2_wnext      = 1'b0;
        mem_wdata     = '0;
        case (state)
            IDLE: begin
                if (arb_any) state_nxt = CMD;
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) state_nxt = DATA;
            end
            DATA: begin
                if (we_q) begin
                    mem_wdata = p2_wdata;
                    p2_wnext  = mem_wready;
                end
                if (beat && (cnt == LAST_BEAT)) state_nxt = DONE;
            end
            DONE: begin
                p1_done   = (gnt_q == GNT_P1);
                p2_done   = (gnt_q == GNT_P2);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning request and count beats of the current burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= GNT_P1;
            addr_q <= '0;
            we_q   <= 1'b0;
            cnt    <= '0;
        end else begin
            if (start) begin
                gnt_q  <= arb_p2 ? GNT_P2 : GNT_P1;
                addr_q <= req_addr & ALIGN_MASK;
                we_q   <= arb_p2 && p2_we;
            end
            if ((state == CMD) && mem_cmd_ready) begin
                cnt <= '0;
            end else if (beat) begin
                // Burst length is a power of two, so the last beat wraps to 0.
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Register read beats into the granted port only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_rvalid <= 1'b0;
            p2_rvalid <= 1'b0;
            p1_rdata  <= '0;
            p2_rdata  <= '0;
        end else begin
            p1_rvalid <= rd_beat && (gnt_q == GNT_P1);
            p2_rvalid <= rd_beat && (gnt_q == GNT_P2);
            if (rd_beat && (gnt_q == GNT_P1)) p1_rdata <= mem_rdata;
            if (rd_beat && (gnt_q == GNT_P2)) p2_rdata <= mem_rdata;
        end
    end

    assign mem_addr = addr_q;
    assign mem_we   = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads, round-robin ties, a
// stalled write burst, command back-pressure, early req drop, spurious
// beats and a mid-burst reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p1_req;
    logic [23:0] p1_addr;
    logic [15:0] p1_rdata;
    logic        p1_rvalid;
    logic        p1_done;
    logic        p2_req;
    logic        p2_we;
    logic [23:0] p2_addr;
    logic [15:0] p2_wdata;
    logic        p2_wnext;
    logic [15:0] p2_rdata;
    logic        p2_rvalid;
    logic        p2_done;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        mem_wready;
    logic [15:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p1_req        (p1_req),
        .p1_addr       (p1_addr),
        .p1_rdata      (p1_rdata),
        .p1_rvalid     (p1_rvalid),
        .p1_done       (p1_done),
        .p2_req        (p2_req),
        .p2_we         (p2_we),
        .p2_addr       (p2_addr),
        .p2_wdata      (p2_wdata),
        .p2_wnext      (p2_wnext),
        .p2_rdata      (p2_rdata),
        .p2_rvalid     (p2_rvalid),
        .p2_done       (p2_done),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_wready    (mem_wready),
        .mem_wdata     (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p1_rdata"},  p1_rdata, 0);
        check({tag, "_p1_rvalid"}, p1_rvalid, 0);
        check({tag, "_p1_done"},   p1_done, 0);
        check({tag, "_p2_wnext"},  p2_wnext, 0);
        check({tag, "_p2_rdata"},  p2_rdata, 0);
        check({tag, "_p2_rvalid"}, p2_rvalid, 0);
        check({tag, "_p2_done"},   p2_done, 0);
        check({tag, "_cmd_valid"}, mem_cmd_valid, 0);
        check({tag, "_mem_we"},    mem_we, 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic drop_req(input int port);
        if (port == 1) p1_req = 1'b0;
        else           p2_req = 1'b0;
    endtask

    // Full read burst starting from IDLE with the port's request already up.
    // cmd_wait: cycles mem_cmd_ready stays low; drop_after: beat after which req falls.
    task automatic read_burst(input int port, input logic [23:0] exp_addr,
                              input logic [15:0] base, input int cmd_wait,
                              input int drop_after);
        logic [15:0] d;
        tick();
        for (int i = 0; i <= cmd_wait; i++) begin
            mem_cmd_ready = (i == cmd_wait);
            mem_rvalid    = (i < cmd_wait);
            mem_rdata     = 16'hDEAD;
            #1;
            check("cmd_valid", mem_cmd_valid, 1);
            check("cmd_addr", mem_addr, exp_addr);
            check("cmd_we", mem_we, 0);
            check("cmd_no_rvalid", {p1_rvalid, p2_rvalid}, 0);
            tick();
        end
        mem_cmd_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            d          = base + 16'(b);
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            tick();
            check("data_cmd_valid", mem_cmd_valid, 0);
            if (port == 1) begin
                check("p1_rvalid", p1_rvalid, 1);
                check("p1_rdata", p1_rdata, d);
                check("p1_done", p1_done, (b == 3));
                check("p2_idle_rvalid", p2_rvalid, 0);
                check("p2_idle_done", p2_done, 0);
            end else begin
                check("p2_rvalid", p2_rvalid, 1);
                check("p2_rdata", p2_rdata, d);
                check("p2_done", p2_done, (b == 3));
                check("p1_idle_rvalid", p1_rvalid, 0);
                check("p1_idle_done", p1_done, 0);
            end
            if (b == drop_after) drop_req(port);
        end
        mem_rvalid = 1'b0;
        drop_req(port);
        tick();
        check("after_done", {p1_done, p2_done, p1_rvalid, p2_rvalid}, 0);
    endtask

    logic [15:0] wr_words [4];
    logic [5:0]  wr_pattern;
    int          wn;

    initial begin
        rst_n         = 1'b0;
        p1_req        = 1'b0;
        p1_addr       = '0;
        p2_req        = 1'b0;
        p2_we         = 1'b0;
        p2_addr       = '0;
        p2_wdata      = '0;
        mem_cmd_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        mem_wready    = 1'b0;

        // Reset state.
        tick();
        tick();
        check_all_zero("reset");

        // Single p1 read, unaligned address is forced to the burst boundary.
        rst_n   = 1'b1;
        p1_req  = 1'b1;
        p1_addr = 24'h000013;
        read_burst(1, 24'h000010, 16'h1000, 0, 4);

        // Simultaneous requests: p2, then p1, then p2 again.
        p1_addr = 24'h000104;
        p2_addr = 24'h00020B;
        p1_req  = 1'b1;
        p2_req  = 1'b1;
        read_burst(2, 24'h000208, 16'h2000, 0, 4);
        p2_req  = 1'b1;
        read_burst(1, 24'h000104, 16'h3000, 0, 4);
        p1_req  = 1'b1;
        read_burst(2, 24'h000208, 16'h4000, 0, 4);
        p1_req  = 1'b0;

        // p2 write with gapped mem_wready on DATA cycles 0, 2, 3, 5.
        wr_words[0] = 16'hA0A0;
        wr_words[1] = 16'hB1B1;
        wr_words[2] = 16'hC2C2;
        wr_words[3] = 16'hD3D3;
        wr_pattern  = 6'b101101;
        wn          = 0;
        p2_req  = 1'b1;
        p2_we   = 1'b1;
        p2_addr = 24'h0000A5;
        tick();
        mem_cmd_ready = 1'b1;
        #1;
        check("wr_cmd_valid", mem_cmd_valid, 1);
        check("wr_cmd_we", mem_we, 1);
        check("wr_cmd_addr", mem_addr, 24'h0000A4);
        tick();
        mem_cmd_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_wready = wr_pattern[k];
            p2_wdata   = wr_words[wn];
            #1;
            check("wr_wdata", mem_wdata, wr_words[wn]);
            check("wr_wnext", p2_wnext, wr_pattern[k]);
            tick();
            if (wr_pattern[k]) wn++;
            check("wr_done", p2_done, (k == 5));
            check("wr_no_rvalid", {p1_rvalid, p2_rvalid, p1_done}, 0);
        end
        mem_wready = 1'b0;
        p2_req     = 1'b0;
        p2_we      = 1'b0;
        p2_wdata   = 16'h5555;
        tick();
        check("wr_idle_wdata", mem_wdata, 0);
        check("wr_idle_done", p2_done, 0);

        // Command held off 5 cycles, then p1 drops req after its first beat.
        p1_req  = 1'b1;
        p1_addr = 24'h123457;
        read_burst(1, 24'h123454, 16'h5000, 5, 0);

        // Spurious memory beats in IDLE are not forwarded.
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        tick();
        tick();
        check("idle_spurious_rvalid", {p1_rvalid, p2_rvalid}, 0);
        check("idle_cmd_valid", mem_cmd_valid, 0);
        mem_rvalid = 1'b0;

        // Reset mid-DATA after two beats, then a fresh p2 read.
        p1_req  = 1'b1;
        p1_addr = 24'h000200;
        tick();
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        mem_rvalid    = 1'b1;
        mem_rdata     = 16'h6000;
        tick();
        mem_rdata     = 16'h6001;
        tick();
        check("pre_reset_rvalid", p1_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        mem_rvalid = 1'b0;
        p1_req     = 1'b0;
        p2_req     = 1'b1;
        p2_we      = 1'b0;
        p2_addr    = 24'h00ABCF;
        tick();
        check_all_zero("held_reset");
        rst_n = 1'b1;
        read_burst(2, 24'h00ABCC, 16'h7000, 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
